// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: config, data-in and result streams between frame controller and FFT core
interface fft_frame_ctrl_if;
  logic        cfg_tvalid;
  logic        cfg_tdata;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  modport master (
    output cfg_tvalid, cfg_tdata, s_tvalid, s_tdata, s_tlast,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );
  modport slave (
    input  cfg_tvalid, cfg_tdata, s_tvalid, s_tdata, s_tlast,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequences config, sample load and result unload of one FFT frame at a time
module fft_frame_ctrl #(
  parameter int FFT_LEN  = 256,
  parameter int DW       = 8,
  parameter int CFG_WORD = 1,
  parameter int TIMEOUT  = 4096,
  parameter int IW       = $clog2(FFT_LEN)
) (
  input  logic                fft_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  input  logic                err_clr,
  input  logic [DW-1:0]       ad_data_in,
  input  logic                ad_valid,
  output logic                ad_ready,
  fft_frame_ctrl_if.master    core,
  output logic                out_valid,
  output logic [31:0]         out_data,
  output logic [IW-1:0]       out_index,
  output logic                out_last,
  output logic                busy,
  output logic                frame_done,
  output logic                err_tlast,
  output logic                err_timeout,
  output logic [15:0]         frame_cnt
);
  typedef enum logic [2:0] {IDLE, CFG, LOAD, WAIT, UNLOAD, DONE} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(FFT_LEN - 1);
  state_t state_q, state_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, out_index_q, out_index_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [31:0] out_data_q, out_data_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic err_tlast_q, err_tlast_d, err_timeout_q, err_timeout_d;
  logic collect, in_xfer, beat, tlast_bad, tmo;
  always_comb begin
    collect   = state_q == WAIT || state_q == UNLOAD;
    in_xfer   = state_q == LOAD && ad_valid && core.s_tready;
    beat      = collect && core.m_tvalid;
    tlast_bad = beat && (core.m_tlast != (out_cnt_q == LAST));
    tmo       = collect && !core.m_tvalid && idle_q == TW'(TIMEOUT - 1);
  end
  always_ff @(posedge fft_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = start ? CFG : IDLE;
      CFG:          state_d = LOAD;
      LOAD:         state_d = in_xfer && in_cnt_q == LAST ? WAIT : LOAD;
      WAIT, UNLOAD: state_d = tlast_bad || tmo ? IDLE :
                              beat && out_cnt_q == LAST ? DONE :
                              beat ? UNLOAD : state_q;
      DONE:         state_d = continuous ? CFG : IDLE;
      default:      state_d = IDLE;
    endcase
  end
  always_comb begin
    core.cfg_tvalid = state_q == CFG;
    core.cfg_tdata  = 1'(CFG_WORD);
    core.s_tvalid   = state_q == LOAD && ad_valid;
    core.s_tdata    = state_q == LOAD ? 32'(ad_data_in) : '0;
    core.s_tlast    = state_q == LOAD && in_cnt_q == LAST;
    ad_ready        = in_xfer;
    busy            = state_q != IDLE;
    frame_done      = state_q == DONE;
    out_valid       = out_valid_q;
    out_data        = out_data_q;
    out_index       = out_index_q;
    out_last        = out_last_q;
    err_tlast       = err_tlast_q;
    err_timeout     = err_timeout_q;
    frame_cnt       = frame_cnt_q;
  end
  always_comb begin
    in_cnt_d      = in_xfer ? in_cnt_q + IW'(1) : in_cnt_q;
    out_cnt_d     = !collect || tlast_bad || tmo ? '0 : beat ? out_cnt_q + IW'(1) : out_cnt_q;
    idle_d        = !collect || core.m_tvalid || tmo ? '0 : idle_q + TW'(1);
    out_valid_d   = beat;
    out_data_d    = beat ? core.m_tdata : out_data_q;
    out_index_d   = beat ? out_cnt_q : out_index_q;
    out_last_d    = beat && out_cnt_q == LAST;
    err_tlast_d   = tlast_bad || (err_tlast_q && !err_clr);
    err_timeout_d = tmo || (err_timeout_q && !err_clr);
    frame_cnt_d   = frame_cnt_q + 16'(state_q == DONE);
  end
  always_ff @(posedge fft_clk) begin
    if (rst) begin
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      idle_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_last_q    <= 1'b0;
      err_tlast_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      idle_q        <= idle_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_index_q   <= out_index_d;
      out_last_q    <= out_last_d;
      err_tlast_q   <= err_tlast_d;
      err_timeout_q <= err_timeout_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end
endmodule
